// File: rtl/sr_flag_arbiter_pkg.sv
// Shared op encodings and the accepted-command record used by the flag arbiter.
package sr_flag_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_TGL = 2'b11;

  // Field widths are sized for the largest supported configuration.
  localparam int CMD_IDXW = 8;
  localparam int CMD_GNTW = 3;

  typedef struct packed {
    logic                valid;
    logic [1:0]          op;
    logic [CMD_IDXW-1:0] idx;
    logic [CMD_GNTW-1:0] gid;
  } cmd_t;

endpackage

// File: rtl/sr_flag_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int GNTW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [GNTW-1:0] gid
);

  logic [GNTW-1:0] ptr;
  int best;
  int best_d;
  int d;

  // The winner is the valid requester with the smallest distance from ptr.
  always_comb begin
    gnt    = '0;
    gid    = '0;
    best   = 0;
    best_d = NREQ;
    d      = 0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + NREQ - int'(ptr)) % NREQ;
      if (req[i] && d < best_d) begin
        best_d = d;
        best   = i;
      end
    end
    if (!reset && best_d < NREQ) begin
      gnt = NREQ'(1) << best;
      gid = GNTW'(best);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && |gnt) begin
      ptr <= GNTW'((int'(gid) + 1) % NREQ);
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Shared SR flag bank: arbitrates set/clear/toggle commands from several
// requesters into one-hot S/R pulses that never overlap.
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8,
  parameter int IDXW   = 3,
  parameter int GNTW   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [IDXW*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  output logic [GNTW-1:0]      grant_id,
  output logic [NFLAGS-1:0]    s_out,
  output logic [NFLAGS-1:0]    r_out,
  output logic [NFLAGS-1:0]    flags,
  output logic                 err
);

  logic [NREQ-1:0]   gnt;
  logic [GNTW-1:0]   gid;
  cmd_t              cmd;
  logic [NFLAGS-1:0] eff;
  logic [NFLAGS-1:0] eff_sh;
  logic [NFLAGS-1:0] one_hot;
  logic [NFLAGS-1:0] s_nxt;
  logic [NFLAGS-1:0] r_nxt;
  logic              err_nxt;
  logic              in_range;

  rr_arbiter #(.NREQ(NREQ), .GNTW(GNTW)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (cmd.valid),
    .gnt     (gnt),
    .gid     (gid)
  );

  assign req_ready = gnt;

  always_comb begin
    cmd.valid = |(req_valid & gnt);
    cmd.op    = req_op[2*gid +: 2];
    cmd.idx   = CMD_IDXW'(req_idx[IDXW*gid +: IDXW]);
    cmd.gid   = CMD_GNTW'(gid);
  end

  // Effective state includes the pulse still in flight, so toggles chain correctly.
  assign eff = (flags | s_out) & ~r_out;

  always_comb begin
    s_nxt    = '0;
    r_nxt    = '0;
    err_nxt  = 1'b0;
    one_hot  = NFLAGS'(1) << cmd.idx;
    eff_sh   = eff >> cmd.idx;
    in_range = int'(cmd.idx) < NFLAGS;
    if (cmd.valid) begin
      if (!in_range) begin
        err_nxt = 1'b1;
      end else begin
        case (cmd.op)
          OP_SET: s_nxt = one_hot;
          OP_CLR: r_nxt = one_hot;
          OP_TGL: begin
            if (eff_sh[0]) r_nxt = one_hot;
            else           s_nxt = one_hot;
          end
          OP_NOP: begin end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags    <= '0;
      s_out    <= '0;
      r_out    <= '0;
      err      <= 1'b0;
      grant_id <= '0;
    end else begin
      flags <= eff;
      s_out <= s_nxt;
      r_out <= r_nxt;
      err   <= err_nxt;
      if (cmd.valid) grant_id <= GNTW'(cmd.gid);
    end
  end

  a_no_overlap: assert property (@(posedge clk) disable iff (reset) (s_out & r_out) == '0);
  a_pulse_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(s_out | r_out));
  a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench for sr_flag_arbiter: directed scenarios followed by random
// traffic checked against a logical flag-bank model.
module tb_sr_flag_arbiter;

  localparam int NREQ   = 4;
  localparam int NFLAGS = 8;
  localparam int IDXW   = 4;
  localparam int GNTW   = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req_valid = '1;
  logic [2*NREQ-1:0]    req_op = 8'hAA;
  logic [IDXW*NREQ-1:0] req_idx = 16'h3210;
  logic [NREQ-1:0]      req_ready;
  logic [GNTW-1:0]      grant_id;
  logic [NFLAGS-1:0]    s_out;
  logic [NFLAGS-1:0]    r_out;
  logic [NFLAGS-1:0]    flags;
  logic                 err;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         gid;
    logic [7:0] s;
    logic [7:0] r;
    logic       err;
    logic [7:0] flags;
  } exp_t;

  exp_t sb[$];
  bit   mflags[NFLAGS];
  int   mptr = 0;
  logic rst_at_edge;
  exp_t p1, p2;
  bit   p1_v = 0, p2_v = 0;

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAGS(NFLAGS), .IDXW(IDXW), .GNTW(GNTW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_idx   (req_idx),
    .req_ready (req_ready),
    .grant_id  (grant_id),
    .s_out     (s_out),
    .r_out     (r_out),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_at_edge <= reset;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Logical model: a flag is just a bit; toggle inverts whatever the bank logically holds.
  task automatic model_accept(input logic [3:0] v, input logic [7:0] ops, input logic [15:0] idxs);
    exp_t e;
    int   w;
    int   idx;
    logic [1:0] op;
    if (v == 0) return;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (w < 0 && v[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
    end
    op    = ops[2*w +: 2];
    idx   = int'(idxs[IDXW*w +: IDXW]);
    e.gid = w;
    e.s   = 8'h00;
    e.r   = 8'h00;
    e.err = 1'b0;
    if (idx >= NFLAGS) begin
      e.err = 1'b1;
    end else if (op == 2'b10 || (op == 2'b11 && !mflags[idx])) begin
      e.s = 8'h01 << idx;
      mflags[idx] = 1'b1;
    end else if (op == 2'b01 || op == 2'b11) begin
      e.r = 8'h01 << idx;
      mflags[idx] = 1'b0;
    end
    e.flags = 8'h00;
    for (int b = 0; b < NFLAGS; b++) e.flags[b] = mflags[b];
    sb.push_back(e);
    mptr = (w + 1) % NREQ;
  endtask

  task automatic apply_stimulus(input logic [3:0] v, input logic [7:0] ops, input logic [15:0] idxs);
    @(posedge clk);
    #1;
    req_valid = v;
    req_op    = ops;
    req_idx   = idxs;
    model_accept(v, ops, idxs);
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(4'h0, 8'h00, 16'h0000);
  endtask

  task automatic do_reset(input int n, input logic [3:0] v);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = v;
    req_op    = 8'hAA;
    req_idx   = 16'h3210;
    for (int b = 0; b < NFLAGS; b++) mflags[b] = 1'b0;
    mptr = 0;
    sb.delete();
    repeat (n) @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = '0;
  endtask

  // Monitor: pops an expectation whenever the DUT accepts, then checks pulses
  // one cycle later and the flag bank the cycle after that.
  initial begin
    exp_t e;
    int   g;
    forever begin
      @(negedge clk);
      if (reset) begin
        p1_v = 0;
        p2_v = 0;
        check_output("ready_in_reset", req_ready, 0);
        if (rst_at_edge) begin
          check_output("reset_flags", flags, 0);
          check_output("reset_s", s_out, 0);
          check_output("reset_r", r_out, 0);
          check_output("reset_err", err, 0);
          check_output("reset_gid", grant_id, 0);
        end
      end else begin
        if (p2_v) check_output("flags", flags, p2.flags);
        if (p1_v) begin
          check_output("s_out", s_out, p1.s);
          check_output("r_out", r_out, p1.r);
          check_output("err", err, p1.err);
          check_output("grant_id", grant_id, p1.gid);
        end else begin
          check_output("idle_pulse", {err, s_out, r_out}, 0);
        end
        p2   = p1;
        p2_v = p1_v;
        p1_v = 0;
        check_output("ready_onehot", $onehot0(req_ready), 1);
        if (|(req_valid & req_ready)) begin
          g = -1;
          for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
          if (sb.size() == 0) begin
            check_output("unexpected_accept", g, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check_output("grant_order", g, e.gid);
            p1   = e;
            p1_v = 1;
          end
        end
      end
    end
  end

  initial begin
    logic [3:0]  v;
    logic [7:0]  ops;
    logic [15:0] idxs;

    do_reset(2, 4'hF);

    apply_stimulus(4'b0001, 8'h02, 16'h0005);
    idle(3);

    do_reset(1, 4'h0);
    repeat (8) apply_stimulus(4'hF, 8'hAA, 16'h3210);
    idle(3);

    do_reset(1, 4'h0);
    repeat (2) apply_stimulus(4'b0100, 8'h30, 16'h0300);
    idle(3);

    apply_stimulus(4'b0010, 8'h08, 16'h0090);
    idle(3);

    apply_stimulus(4'b0001, 8'h02, 16'h0000);
    do_reset(2, 4'h0);
    apply_stimulus(4'hF, 8'hAA, 16'h7654);
    idle(3);

    for (int c = 0; c < 400; c++) begin
      v    = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      ops  = 8'($urandom);
      idxs = '0;
      for (int i = 0; i < NREQ; i++) idxs[IDXW*i +: IDXW] = 4'($urandom_range(0, 9));
      apply_stimulus(v, ops, idxs);
    end
    idle(4);
    check_output("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
